// File: rtl/load_store_unit.sv
// Memory-access stage: one data-memory request per RV32I load/store, with store lane
// alignment, load extension, alignment faults and a request timeout.
module load_store_unit #(
  parameter int TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        ex_valid,
  input  logic        ex_read,
  input  logic        ex_write,
  input  logic [2:0]  ex_funct3,
  input  logic [31:0] ex_addr,
  input  logic [31:0] ex_wdata,
  output logic        lsu_stall,
  output logic        lsu_done,
  output logic [31:0] lsu_rdata,
  output logic        lsu_misalign,
  output logic        lsu_buserr,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [31:0] dmem_wdata,
  output logic [3:0]  dmem_be,
  input  logic        dmem_ack,
  input  logic [31:0] dmem_rdata
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] REQ  = 2'd1;
  localparam logic [1:0] RESP = 2'd2;
  localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  logic [1:0]    state;
  logic [CW-1:0] cnt;
  logic [2:0]    f3_q;
  logic [1:0]    off_q;
  logic          mis_q;
  logic          berr_q;

  logic          mop;
  logic          fault;
  logic [3:0]    be_n;
  logic [31:0]   wdata_n;
  logic [7:0]    byte_sel;
  logic [15:0]   half_sel;
  logic [31:0]   load_val;

  assign mop = ex_valid & (ex_read | ex_write);

  always_comb begin
    fault = (ex_read & ex_write)
          | (ex_funct3[1:0] == 2'b11)
          | (ex_write & ex_funct3[2])
          | ((ex_funct3[1:0] == 2'b01) & ex_addr[0])
          | ((ex_funct3[1:0] == 2'b10) & (ex_addr[1:0] != 2'b00));
  end

  always_comb begin
    be_n    = 4'b1111;
    wdata_n = ex_wdata;
    case (ex_funct3[1:0])
      2'b00: begin
        be_n    = 4'b0001 << ex_addr[1:0];
        wdata_n = {4{ex_wdata[7:0]}};
      end
      2'b01: begin
        be_n    = 4'b0011 << ex_addr[1:0];
        wdata_n = {2{ex_wdata[15:0]}};
      end
      default: begin
        be_n    = 4'b1111;
        wdata_n = ex_wdata;
      end
    endcase
  end

  // funct3[2] selects zero extension; a clear bit sign-extends from the top of the lane.
  always_comb begin
    byte_sel = dmem_rdata[8*off_q +: 8];
    half_sel = off_q[1] ? dmem_rdata[31:16] : dmem_rdata[15:0];
    case (f3_q[1:0])
      2'b00:   load_val = {{24{~f3_q[2] & byte_sel[7]}}, byte_sel};
      2'b01:   load_val = {{16{~f3_q[2] & half_sel[15]}}, half_sel};
      default: load_val = dmem_rdata;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      cnt        <= '0;
      f3_q       <= '0;
      off_q      <= '0;
      mis_q      <= 1'b0;
      berr_q     <= 1'b0;
      lsu_rdata  <= '0;
      dmem_we    <= 1'b0;
      dmem_addr  <= '0;
      dmem_wdata <= '0;
      dmem_be    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (mop) begin
            f3_q       <= ex_funct3;
            off_q      <= ex_addr[1:0];
            dmem_we    <= ex_write;
            dmem_addr  <= {ex_addr[31:2], 2'b00};
            dmem_wdata <= wdata_n;
            dmem_be    <= be_n;
            mis_q      <= fault;
            berr_q     <= 1'b0;
            cnt        <= '0;
            state      <= fault ? RESP : REQ;
          end
        end
        REQ: begin
          if (dmem_ack) begin
            if (!dmem_we) lsu_rdata <= load_val;
            state <= RESP;
          end else if (cnt == CW'(TIMEOUT - 1)) begin
            berr_q <= 1'b1;
            state  <= RESP;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        RESP:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign dmem_req     = (state == REQ);
  assign lsu_done     = (state == RESP);
  assign lsu_misalign = lsu_done & mis_q;
  assign lsu_buserr   = lsu_done & berr_q;
  assign lsu_stall    = ((state == IDLE) & mop) | (state == REQ);

endmodule

// File: tb/tb_load_store_unit.sv
// Bench for load_store_unit: table of load/store vectors against a simple memory responder,
// plus reset-during-access and stray-ack sequences.
module tb_load_store_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        ex_valid, ex_read, ex_write;
  logic [2:0]  ex_funct3;
  logic [31:0] ex_addr, ex_wdata;
  logic        lsu_stall, lsu_done, lsu_misalign, lsu_buserr;
  logic [31:0] lsu_rdata;
  logic        dmem_req, dmem_we, dmem_ack;
  logic [31:0] dmem_addr, dmem_wdata, dmem_rdata;
  logic [3:0]  dmem_be;

  int checks = 0;
  int errors = 0;

  // expected completion record: {rdata, misalign, buserr, request cycles}
  logic [41:0] exp_q[$];

  typedef struct {
    logic        rd;
    logic        wr;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] mem_rdata;
    int          lat;
    logic [3:0]  exp_be;
    logic [31:0] exp_wd;
    logic [31:0] exp_rd;
    logic        exp_mis;
    logic        exp_berr;
    int          exp_nreq;
  } vec_t;

  vec_t vecs[15];
  logic [31:0] last_rd;

  load_store_unit #(.TIMEOUT(8)) dut (
    .clk(clk), .reset(reset),
    .ex_valid(ex_valid), .ex_read(ex_read), .ex_write(ex_write),
    .ex_funct3(ex_funct3), .ex_addr(ex_addr), .ex_wdata(ex_wdata),
    .lsu_stall(lsu_stall), .lsu_done(lsu_done), .lsu_rdata(lsu_rdata),
    .lsu_misalign(lsu_misalign), .lsu_buserr(lsu_buserr),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
    .dmem_wdata(dmem_wdata), .dmem_be(dmem_be),
    .dmem_ack(dmem_ack), .dmem_rdata(dmem_rdata)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic rd, input logic wr, input logic [2:0] f3,
                              input logic [31:0] addr, input logic [31:0] wdata,
                              input logic [31:0] mem_rdata, input int lat,
                              input logic [3:0] be, input logic [31:0] wd,
                              input logic [31:0] rdv, input logic mis,
                              input logic berr, input int nreq);
    vec_t v;
    v.rd = rd; v.wr = wr; v.f3 = f3; v.addr = addr; v.wdata = wdata;
    v.mem_rdata = mem_rdata; v.lat = lat; v.exp_be = be; v.exp_wd = wd;
    v.exp_rd = rdv; v.exp_mis = mis; v.exp_berr = berr; v.exp_nreq = nreq;
    return v;
  endfunction

  // lat = 0 means the memory never acknowledges
  task automatic run_op(input vec_t v);
    int   reqs;
    logic done;
    logic [41:0] e;
    exp_q.push_back({v.exp_rd, v.exp_mis, v.exp_berr, 8'(v.exp_nreq)});
    @(negedge clk);
    ex_valid  = 1'b1;
    ex_read   = v.rd;
    ex_write  = v.wr;
    ex_funct3 = v.f3;
    ex_addr   = v.addr;
    ex_wdata  = v.wdata;
    #1;
    chk("stall_accept", 32'(lsu_stall), 32'd1);
    reqs = 0;
    done = 1'b0;
    for (int c = 0; c < 40 && !done; c++) begin
      @(negedge clk);
      dmem_ack   = 1'b0;
      dmem_rdata = $urandom;
      if (dmem_req) begin
        reqs++;
        if (reqs == 1) begin
          chk("stall_req", 32'(lsu_stall), 32'd1);
          chk("dmem_addr", dmem_addr, v.addr & 32'hFFFF_FFFC);
          chk("dmem_we", 32'(dmem_we), 32'(v.wr));
          chk("dmem_be", 32'(dmem_be), 32'(v.exp_be));
          if (v.wr) chk("dmem_wdata", dmem_wdata, v.exp_wd);
        end
        if (v.lat != 0 && reqs == v.lat) begin
          dmem_ack   = 1'b1;
          dmem_rdata = v.mem_rdata;
        end
      end else if (lsu_done) begin
        done = 1'b1;
        e = exp_q.pop_front();
        chk("lsu_rdata", lsu_rdata, e[41:10]);
        chk("misalign", 32'(lsu_misalign), 32'(e[9]));
        chk("buserr", 32'(lsu_buserr), 32'(e[8]));
        chk("req_cycles", 32'(reqs), 32'(e[7:0]));
        chk("stall_resp", 32'(lsu_stall), 32'd0);
        ex_valid = 1'b0;
      end
    end
    if (!done) begin
      checks++;
      errors++;
      $display("FAIL done_timeout: got no lsu_done expected lsu_done within 40 cycles");
      void'(exp_q.pop_front());
      ex_valid = 1'b0;
    end
  endtask

  initial begin
    reset = 1'b1; ex_valid = 1'b0; ex_read = 1'b0; ex_write = 1'b0;
    ex_funct3 = 3'b0; ex_addr = '0; ex_wdata = '0; dmem_ack = 1'b0; dmem_rdata = '0;

    //          rd wr f3      addr          wdata          mem_rdata      lat be    exp_wd         exp_rd         mis berr nreq
    vecs[0]  = mk(1, 0, 3'b010, 32'h100, 32'h0,          32'hDEADBEEF, 3, 4'hF, 32'h0,         32'hDEADBEEF, 0, 0, 3);
    vecs[1]  = mk(1, 0, 3'b000, 32'h103, 32'h0,          32'h80123456, 1, 4'h8, 32'h0,         32'hFFFFFF80, 0, 0, 1);
    vecs[2]  = mk(1, 0, 3'b100, 32'h103, 32'h0,          32'h80123456, 2, 4'h8, 32'h0,         32'h00000080, 0, 0, 2);
    vecs[3]  = mk(0, 1, 3'b001, 32'h102, 32'h1234ABCD,   32'h0,        1, 4'hC, 32'hABCDABCD,  32'h00000080, 0, 0, 1);
    vecs[4]  = mk(1, 0, 3'b010, 32'h101, 32'h0,          32'h0,        1, 4'h0, 32'h0,         32'h00000080, 1, 0, 0);
    vecs[5]  = mk(1, 1, 3'b010, 32'h100, 32'h0,          32'h0,        1, 4'h0, 32'h0,         32'h00000080, 1, 0, 0);
    vecs[6]  = mk(0, 1, 3'b010, 32'h104, 32'h11223344,   32'h0,        0, 4'hF, 32'h11223344,  32'h00000080, 0, 1, 8);
    vecs[7]  = mk(0, 1, 3'b010, 32'h108, 32'hCAFEF00D,   32'h0,        8, 4'hF, 32'hCAFEF00D,  32'h00000080, 0, 0, 8);
    vecs[8]  = mk(1, 0, 3'b001, 32'h102, 32'h0,          32'h80017FFF, 2, 4'hC, 32'h0,         32'hFFFF8001, 0, 0, 2);
    vecs[9]  = mk(1, 0, 3'b101, 32'h100, 32'h0,          32'h80017FFF, 1, 4'h3, 32'h0,         32'h00007FFF, 0, 0, 1);
    vecs[10] = mk(1, 0, 3'b000, 32'h101, 32'h0,          32'h00007F00, 1, 4'h2, 32'h0,         32'h0000007F, 0, 0, 1);
    vecs[11] = mk(0, 1, 3'b000, 32'h101, 32'h000000A5,   32'h0,        1, 4'h2, 32'hA5A5A5A5,  32'h0000007F, 0, 0, 1);
    vecs[12] = mk(0, 1, 3'b100, 32'h100, 32'h0,          32'h0,        1, 4'h0, 32'h0,         32'h0000007F, 1, 0, 0);
    vecs[13] = mk(1, 0, 3'b011, 32'h100, 32'h0,          32'h0,        1, 4'h0, 32'h0,         32'h0000007F, 1, 0, 0);
    vecs[14] = mk(1, 0, 3'b001, 32'h101, 32'h0,          32'h0,        1, 4'h0, 32'h0,         32'h0000007F, 1, 0, 0);

    repeat (3) @(negedge clk);
    chk("rst_req", 32'(dmem_req), 32'd0);
    chk("rst_done", 32'(lsu_done), 32'd0);
    chk("rst_rdata", lsu_rdata, 32'd0);
    chk("rst_addr", dmem_addr, 32'd0);
    chk("rst_be", 32'(dmem_be), 32'd0);
    chk("rst_wdata", dmem_wdata, 32'd0);
    chk("rst_we", 32'(dmem_we), 32'd0);
    chk("rst_flags", 32'({lsu_misalign, lsu_buserr, lsu_stall}), 32'd0);
    reset = 1'b0;

    for (int i = 0; i < 15; i++) run_op(vecs[i]);
    last_rd = vecs[14].exp_rd;

    // a stray ack while idle must not disturb the load result
    @(negedge clk);
    dmem_ack = 1'b1;
    dmem_rdata = 32'hFFFF_FFFF;
    @(negedge clk);
    dmem_ack = 1'b0;
    chk("stray_ack_rdata", lsu_rdata, last_rd);
    chk("stray_ack_done", 32'(lsu_done), 32'd0);
    chk("stray_ack_req", 32'(dmem_req), 32'd0);

    for (int i = 0; i < 8; i++) begin
      vec_t r;
      logic [31:0] d;
      int lat;
      d = $urandom;
      lat = $urandom_range(1, 8);
      r = mk(1, 0, 3'b010, {22'd0, 8'($urandom_range(0, 255)), 2'b00}, 32'h0, d, lat,
             4'hF, 32'h0, d, 0, 0, lat);
      run_op(r);
    end

    // reset while a request is outstanding
    @(negedge clk);
    ex_valid = 1'b1; ex_read = 1'b1; ex_write = 1'b0; ex_funct3 = 3'b010; ex_addr = 32'h200;
    for (int c = 0; c < 5 && !dmem_req; c++) @(negedge clk);
    chk("pre_reset_req", 32'(dmem_req), 32'd1);
    reset = 1'b1;
    ex_valid = 1'b0;
    @(negedge clk);
    chk("reset_drop_req", 32'(dmem_req), 32'd0);
    chk("reset_no_done", 32'(lsu_done), 32'd0);
    chk("reset_rdata", lsu_rdata, 32'd0);
    reset = 1'b0;
    repeat (3) begin
      @(negedge clk);
      chk("post_reset_no_done", 32'({lsu_done, dmem_req}), 32'd0);
    end
    run_op(mk(1, 0, 3'b010, 32'h10, 32'h0, 32'h13579BDF, 2, 4'hF, 32'h0, 32'h13579BDF, 0, 0, 2));

    repeat (2) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
